param_password_lock: RTL and testbench

//   Parametrised keypad password lock. Collects N_DIGITS digits, one per rising edge of enter,

---
 rtl/param_password_lock_pkg.sv | 13 +
 rtl/param_password_lock_if.sv | 29 ++
 rtl/param_password_lock_timer.sv | 20 ++
 rtl/param_password_lock.sv | 135 +++++++++++++
 tb/tb_param_password_lock.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/param_password_lock_pkg.sv
// param_password_lock_pkg: shared FSM state encoding and width helper for the password lock
package param_password_lock_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    UNLOCKED  = 3'd2,
    SET_ENTRY = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/param_password_lock_if.sv
// param_password_lock_if: keypad inputs and LED/alarm outputs of the password lock
interface param_password_lock_if #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_W      = 4,
  parameter int MAX_ATTEMPTS = 3
);
  localparam int PW    = N_DIGITS * DIGIT_W;
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int CNT_W = $clog2(N_DIGITS + 1);
  logic [DIGIT_W-1:0] i_digit;
  logic               i_enter;
  logic               i_set_pass;
  logic               i_view_pass;
  logic               i_clear;
  logic               o_green_led;
  logic               o_red_led;
  logic               o_alarm;
  logic [PW-1:0]      o_viewed_pass;
  logic [ATT_W-1:0]   o_attempts_left;
  logic [CNT_W-1:0]   o_digit_count;
  modport master (
    output i_digit, i_enter, i_set_pass, i_view_pass, i_clear,
    input  o_green_led, o_red_led, o_alarm, o_viewed_pass, o_attempts_left, o_digit_count
  );
  modport slave (
    input  i_digit, i_enter, i_set_pass, i_view_pass, i_clear,
    output o_green_led, o_red_led, o_alarm, o_viewed_pass, o_attempts_left, o_digit_count
  );
endinterface

// File: rtl/param_password_lock_timer.sv
// lock_timer: loadable down-counter shared by the unlock, set-entry and lockout timeouts
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expired
);
  logic [W-1:0] r_cnt;
  // load takes precedence; otherwise count down and rest at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  // last counted cycle: the owner leaves its state on the next edge
  assign o_expired = (r_cnt == W'(1));
endmodule

// File: rtl/param_password_lock.sv
// param_password_lock: keypad password lock with timed unlock, password change and alarm lockout
module param_password_lock
  import param_password_lock_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_PASS = 16'h1234
) (
  input  logic                 clk,
  input  logic                 reset,
  param_password_lock_if.slave bus
);
  localparam int PW    = N_DIGITS * DIGIT_W;
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam int TW    = $clog2(max2(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_entry, w_entry_nxt;
  logic [PW-1:0]    r_stored, w_stored_nxt;
  logic [PW-1:0]    w_shift;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [ATT_W-1:0] r_att, w_att_nxt;
  logic             r_enter_q;
  logic             w_kp, w_last, w_load, w_expired;
  logic [TW-1:0]    w_load_val;

  assign w_kp    = bus.i_enter & ~r_enter_q;
  assign w_shift = (r_entry << DIGIT_W) | PW'(bus.i_digit);
  assign w_last  = (r_count == CNT_W'(N_DIGITS - 1));

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_val    (w_load_val),
    .o_expired(w_expired)
  );

  // state, entry, stored password, attempt counter and enter edge-detect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_entry   <= '0;
      r_stored  <= DEFAULT_PASS;
      r_count   <= '0;
      r_att     <= ATT_W'(MAX_ATTEMPTS);
      r_enter_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_entry   <= w_entry_nxt;
      r_stored  <= w_stored_nxt;
      r_count   <= w_count_nxt;
      r_att     <= w_att_nxt;
      r_enter_q <= bus.i_enter;
    end
  end

  // next-state logic; clear outranks set_pass, which outranks a keypress or a timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_entry_nxt  = r_entry;
    w_stored_nxt = r_stored;
    w_count_nxt  = r_count;
    w_att_nxt    = r_att;
    w_load       = 1'b0;
    w_load_val   = TW'(UNLOCK_CYCLES);
    case (r_state)
      IDLE: begin
        if (bus.i_clear) begin
          w_entry_nxt = '0;
          w_count_nxt = '0;
        end else if (w_kp) begin
          w_entry_nxt = w_shift;
          w_count_nxt = w_last ? '0 : r_count + CNT_W'(1);
          w_state_nxt = w_last ? CHECK : IDLE;
        end
      end
      CHECK: begin
        w_entry_nxt = '0;
        if (r_entry == r_stored) begin
          w_state_nxt = UNLOCKED;
          w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
          w_load      = 1'b1;
        end else begin
          w_att_nxt   = r_att - ATT_W'(1);
          w_state_nxt = (r_att == ATT_W'(1)) ? LOCKOUT : IDLE;
          w_load      = (r_att == ATT_W'(1));
          w_load_val  = TW'(LOCKOUT_CYCLES);
        end
      end
      UNLOCKED: begin
        if (bus.i_clear) w_state_nxt = IDLE;
        else if (bus.i_set_pass) begin
          w_state_nxt = SET_ENTRY;
          w_load      = 1'b1;
        end else if (w_expired) w_state_nxt = IDLE;
      end
      SET_ENTRY: begin
        if (bus.i_clear) begin
          w_entry_nxt = '0;
          w_count_nxt = '0;
          w_load      = 1'b1;
        end else if (w_kp) begin
          w_load       = 1'b1;
          w_entry_nxt  = w_last ? '0 : w_shift;
          w_count_nxt  = w_last ? '0 : r_count + CNT_W'(1);
          w_stored_nxt = w_last ? w_shift : r_stored;
          w_state_nxt  = w_last ? IDLE : SET_ENTRY;
        end else if (w_expired) begin
          w_entry_nxt = '0;
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      LOCKOUT: begin
        if (w_expired) begin
          w_state_nxt = IDLE;
          w_att_nxt   = ATT_W'(MAX_ATTEMPTS);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.o_green_led     = (r_state == UNLOCKED) || (r_state == SET_ENTRY);
  assign bus.o_red_led       = ~bus.o_green_led;
  assign bus.o_alarm         = (r_state == LOCKOUT);
  assign bus.o_viewed_pass   = ((r_state == UNLOCKED) && bus.i_view_pass) ? r_stored : '0;
  assign bus.o_attempts_left = r_att;
  assign bus.o_digit_count   = r_count;
endmodule

// File: tb/tb_param_password_lock.sv
// tb_param_password_lock: directed scenarios plus randomized keypad traffic against a queue-based model
module tb_param_password_lock;
  localparam int N = 4, DW = 4, MAXA = 3, UNL = 10, LCK = 20;
  localparam logic [15:0] DEF = 16'h1234;
  localparam int M_IDLE = 0, M_CHECK = 1, M_UNL = 2, M_SET = 3, M_LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_password_lock_if #(.N_DIGITS(N), .DIGIT_W(DW), .MAX_ATTEMPTS(MAXA)) bus ();
  param_password_lock #(
    .N_DIGITS(N), .DIGIT_W(DW), .MAX_ATTEMPTS(MAXA),
    .UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK), .DEFAULT_PASS(DEF)
  ) dut (.clk(clk), .reset(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // behavioural model: mode, digits typed so far, remaining time, tries, password
  int          m_mode, m_time, m_tries;
  logic [15:0] m_stored;
  int          m_q[$];
  logic        m_prev, m_press, m_reload;

  function automatic logic [15:0] typed_value();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return 16'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_time = 0; m_tries = MAXA; m_stored = DEF; m_q.delete(); m_prev = 1'b0;
    end else begin
      m_press  = bus.i_enter && !m_prev;
      m_prev   = bus.i_enter;
      m_reload = 1'b0;
      case (m_mode)
        M_IDLE:
          if (bus.i_clear) m_q.delete();
          else if (m_press) begin
            m_q.push_back(int'(bus.i_digit));
            if (m_q.size() == N) m_mode = M_CHECK;
          end
        M_CHECK: begin
          if (typed_value() == m_stored) begin
            m_mode = M_UNL; m_tries = MAXA; m_time = UNL; m_reload = 1'b1;
          end else begin
            m_tries--;
            if (m_tries == 0) begin m_mode = M_LOCK; m_time = LCK; m_reload = 1'b1; end
            else m_mode = M_IDLE;
          end
          m_q.delete();
        end
        M_UNL:
          if (bus.i_clear) m_mode = M_IDLE;
          else if (bus.i_set_pass) begin m_mode = M_SET; m_time = UNL; m_reload = 1'b1; end
          else if (m_time == 1) m_mode = M_IDLE;
        M_SET:
          if (bus.i_clear) begin m_q.delete(); m_time = UNL; m_reload = 1'b1; end
          else if (m_press) begin
            m_q.push_back(int'(bus.i_digit));
            m_time = UNL; m_reload = 1'b1;
            if (m_q.size() == N) begin m_stored = typed_value(); m_q.delete(); m_mode = M_IDLE; end
          end else if (m_time == 1) begin m_q.delete(); m_mode = M_IDLE; end
        default:
          if (m_time == 1) begin m_mode = M_IDLE; m_tries = MAXA; end
      endcase
      if (!m_reload && m_time > 0) m_time--;
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic e_green;
    #2;
    e_green = (m_mode == M_UNL) || (m_mode == M_SET);
    chk("green_led", bus.o_green_led, e_green);
    chk("red_led", bus.o_red_led, !e_green);
    chk("alarm", bus.o_alarm, m_mode == M_LOCK);
    chk("viewed_pass", bus.o_viewed_pass, (m_mode == M_UNL && bus.i_view_pass) ? m_stored : 16'h0);
    chk("attempts_left", bus.o_attempts_left, m_tries);
    chk("digit_count", bus.o_digit_count, (m_mode == M_IDLE || m_mode == M_SET) ? m_q.size() : 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    bus.i_digit = d;
    bus.i_enter = 1'b1;
    @(negedge clk);
    bus.i_enter = 1'b0;
    #2;
  endtask

  task automatic keys(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
  endtask

  task automatic pulse_clear();
    @(negedge clk); bus.i_clear = 1'b1;
    @(negedge clk); bus.i_clear = 1'b0;
    #2;
  endtask

  task automatic pulse_set();
    @(negedge clk); bus.i_set_pass = 1'b1;
    @(negedge clk); bus.i_set_pass = 1'b0;
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_green"}, bus.o_green_led, 0);
    chk({tag, "_red"}, bus.o_red_led, 1);
    chk({tag, "_alarm"}, bus.o_alarm, 0);
    chk({tag, "_viewed"}, bus.o_viewed_pass, 0);
    chk({tag, "_attempts"}, bus.o_attempts_left, 3);
    chk({tag, "_count"}, bus.o_digit_count, 0);
  endtask

  initial begin
    bus.i_digit = '0; bus.i_enter = 1'b0; bus.i_set_pass = 1'b0;
    bus.i_view_pass = 1'b0; bus.i_clear = 1'b0;
    tick(3);
    chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b0; #2;

    keys(16'h1234);
    chk("t1_check_cycle_locked", bus.o_green_led, 0);
    tick(1);
    chk("t1_unlocked", bus.o_green_led, 1);
    chk("t1_attempts", bus.o_attempts_left, 3);
    tick(9);
    chk("t1_last_unlocked_cycle", bus.o_green_led, 1);
    tick(1);
    chk("t1_relocked", bus.o_red_led, 1);

    for (int g = 0; g < 3; g++) begin
      keys(16'h1235);
      tick(1);
      chk("t2_attempts", bus.o_attempts_left, 2 - g);
    end
    chk("t2_alarm_on", bus.o_alarm, 1);
    keys(16'h1234);
    chk("t2_keys_ignored", bus.o_digit_count, 0);
    tick(11);
    chk("t2_alarm_last_cycle", bus.o_alarm, 1);
    tick(1);
    chk("t2_alarm_off", bus.o_alarm, 0);
    chk("t2_attempts_restored", bus.o_attempts_left, 3);

    keys(16'h1234); tick(1);
    pulse_set();
    chk("t3_set_entry_green", bus.o_green_led, 1);
    keys(16'h9876);
    chk("t3_relocked", bus.o_green_led, 0);
    keys(16'h1234); tick(1);
    chk("t3_old_pass_rejected", bus.o_attempts_left, 2);
    keys(16'h9876); tick(1);
    chk("t3_new_pass_unlocks", bus.o_green_led, 1);
    chk("t3_attempts_restored", bus.o_attempts_left, 3);

    pulse_set();
    press(4'h5);
    chk("t6_partial_count", bus.o_digit_count, 1);
    @(negedge clk); #3 rst = 1'b1; #1;
    chk_reset_outputs("t6_async_reset");
    @(negedge clk); rst = 1'b0; #2;
    keys(16'h1234); tick(1);
    chk("t6_default_restored", bus.o_green_led, 1);

    bus.i_view_pass = 1'b1; #1;
    chk("t4_view_unlocked", bus.o_viewed_pass, 16'h1234);
    pulse_clear();
    chk("t4_clear_relocks", bus.o_green_led, 0);
    chk("t4_view_locked", bus.o_viewed_pass, 16'h0000);
    bus.i_view_pass = 1'b0;

    press(4'h1); press(4'h2);
    chk("t5_two_digits", bus.o_digit_count, 2);
    pulse_clear();
    chk("t5_cleared_count", bus.o_digit_count, 0);
    chk("t5_no_attempt_used", bus.o_attempts_left, 3);
    @(negedge clk); bus.i_digit = 4'h7; bus.i_enter = 1'b1;
    repeat (5) @(negedge clk);
    bus.i_enter = 1'b0; #2;
    chk("t5_held_enter_once", bus.o_digit_count, 1);
    pulse_clear();

    for (int c = 0; c < 3000; c++) begin
      logic quiet;
      int   idx;
      @(negedge clk);
      quiet = (c % 250) >= 200;
      idx = m_q.size();
      bus.i_enter     = quiet ? 1'b0 : 1'($urandom % 2);
      bus.i_digit     = ($urandom % 4 == 0 || idx >= N) ? 4'($urandom) : 4'(m_stored >> (4 * (N - 1 - idx)));
      bus.i_clear     = !quiet && ($urandom % 50 == 0);
      bus.i_set_pass  = !quiet && ($urandom % 8 == 0);
      bus.i_view_pass = 1'($urandom % 2);
    end
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
